if_id_skid_regs: RTL and testbench
==================================

// Module: if_id_skid_regs
// PURPOSE
//  IF->ID pipeline boundary, directly upstream of the ID/EX register stage.
//  Captures {pc, inst, fetch-error} beats from the fetch unit into a 2-entry skid buffer.
//  Presents them to decode over a valid/ready handshake.
//  Decouples fetch from decode/hazard stalls without losing beats, and drops all
//  in-flight beats on a branch/jump redirect flush.
// PARAMETERS
//  PC_W      64              pc width
//  INST_W    32              instruction width
//  RESET_PC  64'h8000_0000   out_pc value after reset
//  NOP_INST  32'h0000_0013   instruction presented while empty (addi x0,x0,0)
// PORTS
//  clk        in   1       sole clock, rising edge
//  rst        in   1       synchronous reset, active-high
//  in_valid   in   1       fetch beat valid
//  in_ready   out  1       buffer can accept a beat this cycle
//  in_pc      in   PC_W    pc of fetched instruction
//  in_inst    in   INST_W  fetched instruction
//  in_err     in   1       fetch access fault for this beat
//  out_valid  out  1       head entry valid toward decode
//  out_ready  in   1       decode consumes head this cycle
//  out_pc     out  PC_W    head pc
//  out_inst   out  INST_W  head instruction, NOP_INST when empty
//  out_err    out  1       head fetch-fault flag, 0 when empty
//  flush      in   1       redirect from EX (branch/jump/jalr taken)
//  occ        out  2       current occupancy 0..2
// BEHAVIOUR
//  - Storage: two entries (head, tail) plus 2-bit count; push = in_valid&in_ready,
//    pop = out_valid&out_ready.
//  - in_ready = (count != 2), derived from registered count only; never depends
//    on out_ready (no comb ready path through the block).
//  - out_valid = (count != 0); head fields drive out_* directly from flops.
//  - Latency: a beat pushed at edge N is visible on out_* after edge N (1 cycle).
//  - count 0: push -> head, count 1. Pop is impossible.
//  - count 1: push only -> tail, count 2. Pop only -> count 0.
//    Push and pop together -> new beat to head, count stays 1.
//  - count 2: pop -> tail moves to head, count 1. Push is impossible (in_ready=0).
//  - Empty: out_inst=NOP_INST, out_err=0; out_pc holds the last head pc
//    (RESET_PC after reset).
//  - flush (sync): count<=0 next edge; any same-cycle push is discarded,
//    as is any same-cycle pop (decode squashes it). out_pc keeps its value.
//    flush beats push/pop. in_ready still follows the pre-flush count that cycle.
//  - rst has priority over flush: count=0, out_pc=RESET_PC, out_inst=NOP_INST,
//    out_err=0, out_valid=0, in_ready=1, occ=0, tail contents cleared to 0.
//    Mid-operation rst drops all entries at that edge.
//  - Beats never reorder or duplicate. A held in_valid beat may not change while
//    in_ready=0 (upstream rule; checked by assertion).
// STRUCTURE
//  - rvseed_defines.v gains `RESET_PC, `NOP_INST, `INST_WIDTH; CPU_WIDTH is reused
//    for PC_W.
//  - One natural sub-module: pipe_skid_buf (generic 2-entry valid/ready buffer,
//    DATA_W = PC_W+INST_W+1), also reusable for ID/EX back-pressure.
//    This wrapper adds the NOP/RESET_PC presentation and flush.
// TESTING
//  1. rst held 2 cycles, release -> out_valid=0, out_pc=8000_0000, out_inst=0000_0013,
//     in_ready=1, occ=0.
//  2. Stream pc 8000_0000/04/08 with out_ready=1 -> each appears 1 cycle later,
//     occ stays 1, no bubbles.
//  3. out_ready=0, push 8000_0000 and 8000_0004 -> occ=2, in_ready=0.
//     Release out_ready -> 8000_0000 then 8000_0004 in order.
//  4. occ=2, assert flush with in_valid pc 8000_0010 -> next cycle occ=0,
//     out_valid=0, out_pc unchanged; 8000_0010 not delivered.
//  5. in_err=1 on pc 8000_0008 -> out_err=1 only while that beat is head.
//  6. rst asserted at occ=2 with flush=1 -> reset values of test 1 next cycle.
//     Random valid/ready scoreboard shows no loss or duplication.

Source files
------------

// File: rtl/if_id_skid_regs_pkg.sv
// Shared defaults and the occupancy state type for the IF->ID skid stage.
package if_id_skid_regs_pkg;

    localparam int          DEFAULT_PC_W     = 64;
    localparam int          DEFAULT_INST_W   = 32;
    localparam logic [63:0] DEFAULT_RESET_PC = 64'h8000_0000;
    localparam logic [31:0] DEFAULT_NOP_INST = 32'h0000_0013;

    // Encoding equals the occupancy count, so occ is the state register itself.
    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_FULL  = 2'd2
    } buf_state_t;

endpackage

// File: rtl/if_id_skid_regs_skid_buf.sv
// Generic 2-entry valid/ready skid buffer with synchronous flush.
// Ready and valid come only from registered occupancy, so there is no combinational path from out_ready to in_ready.
module pipe_skid_buf
    import if_id_skid_regs_pkg::*;
#(
    parameter int                DATA_W     = 97,
    parameter logic [DATA_W-1:0] RESET_HEAD = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occ
);

    buf_state_t        state;
    buf_state_t        state_nxt;
    logic [DATA_W-1:0] head_q;
    logic [DATA_W-1:0] tail_q;
    logic              push;
    logic              pop;
    logic              load_head;
    logic              head_from_tail;
    logic              load_tail;

    assign in_ready  = (state != BUF_FULL);
    assign out_valid = (state != BUF_EMPTY);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= BUF_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = BUF_EMPTY;
        end else begin
            case (state)
                BUF_EMPTY: if (push) state_nxt = BUF_ONE;
                BUF_ONE: begin
                    if (push && !pop) begin
                        state_nxt = BUF_FULL;
                    end else if (!push && pop) begin
                        state_nxt = BUF_EMPTY;
                    end
                end
                BUF_FULL:  if (pop) state_nxt = BUF_ONE;
                default:   state_nxt = BUF_EMPTY;
            endcase
        end
    end

    // A flush suppresses every data move so the head (and thus out_pc) holds.
    always_comb begin
        load_head      = 1'b0;
        head_from_tail = 1'b0;
        load_tail      = 1'b0;
        if (!flush) begin
            case (state)
                BUF_EMPTY: load_head = push;
                BUF_ONE: begin
                    load_head = push && pop;
                    load_tail = push && !pop;
                end
                BUF_FULL: begin
                    load_head      = pop;
                    head_from_tail = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q <= RESET_HEAD;
            tail_q <= '0;
        end else begin
            if (load_head) begin
                head_q <= head_from_tail ? tail_q : in_data;
            end
            if (load_tail) begin
                tail_q <= in_data;
            end
        end
    end

    assign out_data = head_q;
    assign occ      = state;

endmodule

// File: rtl/if_id_skid_regs.sv
// IF->ID boundary: 2-entry skid buffer of {pc, inst, err} beats with redirect flush.
// Presents NOP_INST with a cleared fault flag while empty; out_pc keeps the last head pc.
module if_id_skid_regs
    import if_id_skid_regs_pkg::*;
#(
    parameter int                PC_W     = DEFAULT_PC_W,
    parameter int                INST_W   = DEFAULT_INST_W,
    parameter logic [PC_W-1:0]   RESET_PC = DEFAULT_RESET_PC[PC_W-1:0],
    parameter logic [INST_W-1:0] NOP_INST = DEFAULT_NOP_INST[INST_W-1:0]
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PC_W-1:0]   in_pc,
    input  logic [INST_W-1:0] in_inst,
    input  logic              in_err,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PC_W-1:0]   out_pc,
    output logic [INST_W-1:0] out_inst,
    output logic              out_err,
    input  logic              flush,
    output logic [1:0]        occ
);

    localparam int DATA_W = PC_W + INST_W + 1;

    logic [DATA_W-1:0] head;
    logic              stall_q;
    logic [DATA_W-1:0] stall_beat_q;

    pipe_skid_buf #(
        .DATA_W     (DATA_W),
        .RESET_HEAD ({RESET_PC, NOP_INST, 1'b0})
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   ({in_pc, in_inst, in_err}),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (head),
        .occ       (occ)
    );

    assign out_pc   = head[DATA_W-1 -: PC_W];
    assign out_inst = out_valid ? head[INST_W:1] : NOP_INST;
    assign out_err  = out_valid & head[0];

    // Fetch must hold a refused beat steady until accepted; a redirect releases it.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= 1'b0;
        end else begin
            stall_q <= in_valid && !in_ready && !flush;
        end
        stall_beat_q <= {in_pc, in_inst, in_err};
    end

    held_beat_stable: assert property (@(posedge clk) disable iff (rst)
        stall_q |-> (in_valid && ({in_pc, in_inst, in_err} == stall_beat_q)));

endmodule

// File: tb/tb_if_id_skid_regs.sv
// Bench for if_id_skid_regs: directed scenarios with literal expectations, then randomized traffic
// checked every cycle against a queue-based reference model.
module tb_if_id_skid_regs;

    localparam logic [63:0] RESET_PC = 64'h8000_0000;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] inst;
        logic        err;
    } beat_t;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_pc;
    logic [31:0] in_inst;
    logic        in_err;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_pc;
    logic [31:0] out_inst;
    logic        out_err;
    logic        flush;
    logic [1:0]  occ;

    int    vectors     = 0;
    int    miscompares = 0;
    beat_t mq[$];
    logic [63:0] last_pc = RESET_PC;
    bit    live = 0;

    if_id_skid_regs dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pc     (in_pc),
        .in_inst   (in_inst),
        .in_err    (in_err),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .out_inst  (out_inst),
        .out_err   (out_err),
        .flush     (flush),
        .occ       (occ)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [63:0] pc, input logic [31:0] inst,
                                 input logic err, input logic rdy, input logic fl, input logic r);
        in_valid  = v;
        in_pc     = pc;
        in_inst   = inst;
        in_err    = err;
        out_ready = rdy;
        flush     = fl;
        rst       = r;
        @(negedge clk);
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 64'h0, 32'h0, 1'b0, rdy, 1'b0, 1'b0);
    endtask

    // Reference model: a FIFO of at most two beats, updated from the inputs seen at each edge.
    always @(posedge clk) begin
        bit can_push;
        bit can_pop;
        beat_t b;
        if (rst) begin
            mq.delete();
            last_pc = RESET_PC;
            live = 1;
        end else if (live) begin
            can_push = in_valid && (mq.size() < 2);
            can_pop  = out_ready && (mq.size() > 0);
            if (flush) begin
                mq.delete();
            end else begin
                if (can_pop) void'(mq.pop_front());
                if (can_push) begin
                    b.pc = in_pc; b.inst = in_inst; b.err = in_err;
                    mq.push_back(b);
                end
            end
            if (mq.size() > 0) last_pc = mq[0].pc;
        end
        #1;
        if (live) begin
            checkOutput("cyc_out_valid", 64'(out_valid), 64'(mq.size() != 0));
            checkOutput("cyc_in_ready", 64'(in_ready), 64'(mq.size() != 2));
            checkOutput("cyc_occ", 64'(occ), 64'(mq.size()));
            checkOutput("cyc_out_pc", out_pc, last_pc);
            checkOutput("cyc_out_inst", 64'(out_inst), 64'((mq.size() != 0) ? mq[0].inst : NOP_INST));
            checkOutput("cyc_out_err", 64'(out_err), 64'((mq.size() != 0) ? mq[0].err : 1'b0));
        end
    end

    initial begin
        logic        hold;
        logic        v;
        logic        rdy_now;
        logic        fl;
        logic        r;
        logic        rdy;
        logic [63:0] pc;
        logic [63:0] next_pc;
        logic [31:0] inst;
        logic        err;

        in_valid = 1'b0; in_pc = '0; in_inst = '0; in_err = 1'b0;
        out_ready = 1'b0; flush = 1'b0; rst = 1'b1;

        // Reset held two cycles
        applyStimulus(1'b0, 64'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 64'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(1, 1'b0);
        checkOutput("rst_out_valid", 64'(out_valid), 64'h0);
        checkOutput("rst_out_pc", out_pc, 64'h8000_0000);
        checkOutput("rst_out_inst", 64'(out_inst), 64'h13);
        checkOutput("rst_in_ready", 64'(in_ready), 64'h1);
        checkOutput("rst_occ", 64'(occ), 64'h0);

        // Streaming with decode always ready
        applyStimulus(1'b1, 64'h8000_0000, 32'h1111_1111, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("stream0_pc", out_pc, 64'h8000_0000);
        checkOutput("stream0_occ", 64'(occ), 64'h1);
        applyStimulus(1'b1, 64'h8000_0004, 32'h2222_2222, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("stream1_pc", out_pc, 64'h8000_0004);
        checkOutput("stream1_inst", 64'(out_inst), 64'h2222_2222);
        applyStimulus(1'b1, 64'h8000_0008, 32'h3333_3333, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("stream2_pc", out_pc, 64'h8000_0008);
        checkOutput("stream2_occ", 64'(occ), 64'h1);
        idle(1, 1'b1);
        checkOutput("drain_out_pc_held", out_pc, 64'h8000_0008);
        checkOutput("drain_out_inst_nop", 64'(out_inst), 64'h13);

        // Back-pressure fills both entries, release drains in order
        applyStimulus(1'b1, 64'h8000_0000, 32'hAAAA_0000, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 64'h8000_0004, 32'hAAAA_0004, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("full_occ", 64'(occ), 64'h2);
        checkOutput("full_in_ready", 64'(in_ready), 64'h0);
        checkOutput("full_head_pc", out_pc, 64'h8000_0000);
        idle(1, 1'b1);
        checkOutput("release1_pc", out_pc, 64'h8000_0004);
        checkOutput("release1_occ", 64'(occ), 64'h1);
        idle(1, 1'b1);
        checkOutput("release2_occ", 64'(occ), 64'h0);

        // Flush while full discards both entries and the same-cycle beat
        applyStimulus(1'b1, 64'h8000_0020, 32'hBBBB_0020, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 64'h8000_0024, 32'hBBBB_0024, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 64'h8000_0010, 32'hBBBB_0010, 1'b0, 1'b1, 1'b1, 1'b0);
        checkOutput("flush_occ", 64'(occ), 64'h0);
        checkOutput("flush_out_valid", 64'(out_valid), 64'h0);
        checkOutput("flush_out_pc_kept", out_pc, 64'h8000_0020);
        idle(2, 1'b1);
        checkOutput("flush_no_deliver", 64'(out_valid), 64'h0);

        // Fetch fault flag follows its beat only
        applyStimulus(1'b1, 64'h8000_0008, 32'hCCCC_0008, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("err_head", 64'(out_err), 64'h1);
        applyStimulus(1'b1, 64'h8000_000C, 32'hCCCC_000C, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("err_head_full", 64'(out_err), 64'h1);
        idle(1, 1'b1);
        checkOutput("err_next_head", 64'(out_err), 64'h0);
        idle(2, 1'b1);

        // Reset beats flush at occupancy 2
        applyStimulus(1'b1, 64'h8000_0040, 32'hDDDD_0040, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 64'h8000_0044, 32'hDDDD_0044, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 64'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
        checkOutput("rstfl_out_valid", 64'(out_valid), 64'h0);
        checkOutput("rstfl_out_pc", out_pc, 64'h8000_0000);
        checkOutput("rstfl_out_inst", 64'(out_inst), 64'h13);
        checkOutput("rstfl_in_ready", 64'(in_ready), 64'h1);
        checkOutput("rstfl_occ", 64'(occ), 64'h0);
        idle(1, 1'b0);

        // Random traffic obeying the hold-until-accepted rule
        hold    = 1'b0;
        next_pc = 64'h8000_1000;
        pc = '0; inst = '0; err = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (hold) begin
                v = 1'b1;
            end else begin
                v = ($urandom_range(0, 3) != 0);
                if (v) begin
                    pc      = next_pc;
                    next_pc = next_pc + 64'd4;
                    inst    = $urandom;
                    err     = ($urandom_range(0, 7) == 0);
                end
            end
            rdy     = ($urandom_range(0, 3) != 0);
            fl      = ($urandom_range(0, 31) == 0);
            r       = ($urandom_range(0, 199) == 0);
            rdy_now = (mq.size() < 2);
            applyStimulus(v, pc, inst, err, rdy, fl, r);
            hold = v && !rdy_now && !fl && !r;
        end
        idle(3, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
